// File: rtl/shift_reg_pkg.sv
// Shared types for the multi-lane shift register: operation modes and their width.
package shift_reg_pkg;

  localparam int MODE_W = 2;

  typedef enum logic [MODE_W-1:0] {
    MODE_HOLD       = 2'd0,
    MODE_SHIFT_UP   = 2'd1,
    MODE_SHIFT_DOWN = 2'd2,
    MODE_LOAD       = 2'd3
  } mode_e;

  // Fill counter width needed to represent 0..depth inclusive.
  function automatic int fill_cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/shift_reg_edge_detect.sv
// Single-bit registered rising-edge detector. History samples on every edge so a
// held 1 yields exactly one pulse, independent of any enable in the parent.
module shift_reg_edge_detect (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic rise_o
);

  logic hist_q;
  logic rise_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hist_q <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      hist_q <= d_i;
      rise_q <= d_i & ~hist_q;
    end
  end

  assign rise_o = rise_q;

endmodule

// File: rtl/shift_reg_multi.sv
// DEPTH x WIDTH shift register with up/down shift, parallel load, hold, saturating
// fill counter and optional tap rising-edge detect (SHIFT_REG_TAP_DETECT_EN).
module shift_reg_multi
  import shift_reg_pkg::*;
#(
  parameter int WIDTH = 1,
  parameter int DEPTH = 4,
  parameter int TAP   = DEPTH - 1
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic                          enable,
  input  logic [MODE_W-1:0]             mode,
  input  logic [WIDTH-1:0]              serial_in_lo,
  input  logic [WIDTH-1:0]              serial_in_hi,
  input  logic [DEPTH*WIDTH-1:0]        load_data,
  output logic [DEPTH*WIDTH-1:0]        parallel_out,
  output logic [WIDTH-1:0]              serial_out_hi,
  output logic [WIDTH-1:0]              serial_out_lo,
  output logic [$clog2(DEPTH+1)-1:0]    fill_count,
  output logic                          full,
  output logic                          tap_rise
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] FILL_MAX = CNT_W'(DEPTH);

  // Packed so stage k lands at [k*WIDTH +: WIDTH], matching load_data/parallel_out.
  logic [DEPTH-1:0][WIDTH-1:0] stage_q, stage_d;
  logic [CNT_W-1:0]            fill_q, fill_d;
  mode_e                       mode_s;

  assign mode_s = mode_e'(mode);

  always_comb begin
    stage_d = stage_q;
    fill_d  = fill_q;
    case (mode_s)
      MODE_SHIFT_UP: begin
        stage_d = {stage_q[DEPTH-2:0], serial_in_lo};
        if (fill_q != FILL_MAX) fill_d = fill_q + 1'b1;
      end
      MODE_SHIFT_DOWN: begin
        stage_d = {serial_in_hi, stage_q[DEPTH-1:1]};
        if (fill_q != FILL_MAX) fill_d = fill_q + 1'b1;
      end
      MODE_LOAD: begin
        stage_d = load_data;
        fill_d  = FILL_MAX;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stage_q <= '0;
      fill_q  <= '0;
    end else if (enable) begin
      stage_q <= stage_d;
      fill_q  <= fill_d;
    end
  end

  assign parallel_out  = stage_q;
  assign serial_out_lo = stage_q[0];
  assign serial_out_hi = stage_q[DEPTH-1];
  assign fill_count    = fill_q;
  assign full          = (fill_q == FILL_MAX);

`ifdef SHIFT_REG_TAP_DETECT_EN
  shift_reg_edge_detect u_tap_edge (
    .clk_i  (clock),
    .rst_ni (reset_n),
    .d_i    (stage_q[TAP][0]),
    .rise_o (tap_rise)
  );
`else
  assign tap_rise = 1'b0;
`endif

endmodule

// File: tb/tb_shift_reg_multi.sv
// Directed bench for shift_reg_multi (WIDTH=2, DEPTH=4, TAP=3) with an array model
// checked every cycle and hand-computed literal checkpoints.
module tb_shift_reg_multi;
  import shift_reg_pkg::*;

  localparam int W   = 2;
  localparam int D   = 4;
  localparam int TAP = 3;
  localparam int CW  = $clog2(D + 1);
`ifdef SHIFT_REG_TAP_DETECT_EN
  localparam bit TAP_EN = 1'b1;
`else
  localparam bit TAP_EN = 1'b0;
`endif

  logic           clock = 1'b0;
  logic           reset_n = 1'b0;
  logic           enable = 1'b0;
  logic [1:0]     mode = 2'd0;
  logic [W-1:0]   serial_in_lo = '0;
  logic [W-1:0]   serial_in_hi = '0;
  logic [D*W-1:0] load_data = '0;
  logic [D*W-1:0] parallel_out;
  logic [W-1:0]   serial_out_hi, serial_out_lo;
  logic [CW-1:0]  fill_count;
  logic           full, tap_rise;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] m_st [D];
  int           m_fill;
  bit           m_hist, m_rise;
  bit           model_live = 1'b0;

  shift_reg_multi #(.WIDTH(W), .DEPTH(D), .TAP(TAP)) dut (
    .clock(clock), .reset_n(reset_n), .enable(enable), .mode(mode),
    .serial_in_lo(serial_in_lo), .serial_in_hi(serial_in_hi), .load_data(load_data),
    .parallel_out(parallel_out), .serial_out_hi(serial_out_hi), .serial_out_lo(serial_out_lo),
    .fill_count(fill_count), .full(full), .tap_rise(tap_rise)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [D*W-1:0] m_par();
    logic [D*W-1:0] r;
    for (int k = 0; k < D; k++) r[k*W +: W] = m_st[k];
    return r;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < D; k++) m_st[k] = '0;
    m_fill = 0;
    m_hist = 1'b0;
    m_rise = 1'b0;
  endtask

  // Behaviour at one rising edge, from the inputs as driven before it.
  task automatic model_edge();
    bit tapbit;
    tapbit = m_st[TAP][0];
    m_rise = TAP_EN && tapbit && !m_hist;
    m_hist = tapbit;
    if (enable) begin
      case (mode)
        2'd1: begin
          for (int k = D - 1; k > 0; k--) m_st[k] = m_st[k-1];
          m_st[0] = serial_in_lo;
          m_fill = (m_fill < D) ? m_fill + 1 : D;
        end
        2'd2: begin
          for (int k = 0; k < D - 1; k++) m_st[k] = m_st[k+1];
          m_st[D-1] = serial_in_hi;
          m_fill = (m_fill < D) ? m_fill + 1 : D;
        end
        2'd3: begin
          for (int k = 0; k < D; k++) m_st[k] = load_data[k*W +: W];
          m_fill = D;
        end
        default: ;
      endcase
    end
  endtask

  task automatic cyc(input bit en, input logic [1:0] md, input logic [W-1:0] lo,
                     input logic [W-1:0] hi, input logic [D*W-1:0] ld);
    @(negedge clock);
    enable = en; mode = md; serial_in_lo = lo; serial_in_hi = hi; load_data = ld;
    @(posedge clock);
    model_edge();
  endtask

  // Every-cycle comparison against the model.
  always @(posedge clock) begin
    #1;
    if (reset_n && model_live) begin
      chk("par", parallel_out, m_par());
      chk("so_lo", serial_out_lo, m_st[0]);
      chk("so_hi", serial_out_hi, m_st[D-1]);
      chk("fill", fill_count, m_fill);
      chk("full", full, m_fill == D);
      chk("rise", tap_rise, m_rise);
    end
  end

  initial begin
    int pulses;
    logic [W-1:0] seq [4];
    seq = '{2'd1, 2'd0, 2'd1, 2'd1};
    model_reset();
    model_live = 1'b1;
    @(posedge clock); @(posedge clock);
    #2;
    chk("rst_par", parallel_out, 0);
    chk("rst_fill", fill_count, 0);
    chk("rst_full", full, 0);
    chk("rst_rise", tap_rise, 0);
    reset_n = 1'b1;

    // Shift in 1,0,1,1 from the low end.
    for (int i = 0; i < 4; i++) begin
      cyc(1, MODE_SHIFT_UP, seq[i], 0, 0);
      #1;
      chk("up_fill", fill_count, i + 1);
      chk("up_full", full, i == 3);
    end
    chk("up_par", parallel_out, 8'h45);
    cyc(1, MODE_SHIFT_UP, 2'd2, 0, 0);
    #1;
    chk("sat_fill", fill_count, 4);
    chk("sat_par", parallel_out, 8'h16);

    // Load then one shift down.
    cyc(1, MODE_LOAD, 0, 0, 8'hA5);
    #1 chk("load_par", parallel_out, 8'hA5);
    cyc(1, MODE_SHIFT_DOWN, 0, 2'b11, 0);
    #1;
    chk("down_par", parallel_out, 8'hE9);
    chk("down_fill", fill_count, 4);

    // Disabled edges hold everything.
    for (int i = 0; i < 3; i++) cyc(0, MODE_SHIFT_UP, 2'd3, 2'd3, 8'hFF);
    #1;
    chk("hold_par", parallel_out, 8'hE9);
    chk("hold_fill", fill_count, 4);

    // Asynchronous reset between edges while full.
    #1 reset_n = 1'b0;
    #1;
    chk("arst_par", parallel_out, 0);
    chk("arst_fill", fill_count, 0);
    chk("arst_full", full, 0);
    chk("arst_rise", tap_rise, 0);
    model_reset();
    reset_n = 1'b1;
    cyc(1, MODE_SHIFT_UP, 0, 0, 0);
    #1 chk("post_rst_fill", fill_count, 1);

    // Single 1 injected: pulse 4 edges later, for one cycle.
    for (int i = 0; i < 7; i++) begin
      cyc(1, MODE_SHIFT_UP, (i == 0) ? 2'd1 : 2'd0, 0, 0);
      #1 chk("tap_single", tap_rise, TAP_EN && (i == 4));
    end

    // Run of three 1s: a single pulse.
    pulses = 0;
    for (int i = 0; i < 9; i++) begin
      cyc(1, MODE_SHIFT_UP, (i < 3) ? 2'd1 : 2'd0, 0, 0);
      #1 if (tap_rise) pulses++;
    end
    chk("tap_run_pulses", pulses, TAP_EN ? 1 : 0);

    // Tap becomes 1 and enable drops straight after: still one pulse.
    pulses = 0;
    cyc(1, MODE_SHIFT_UP, 2'd1, 0, 0);
    for (int i = 0; i < 3; i++) cyc(1, MODE_SHIFT_UP, 2'd0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      cyc(0, MODE_SHIFT_UP, 2'd0, 0, 0);
      #1 if (tap_rise) pulses++;
    end
    chk("tap_en_low_pulses", pulses, TAP_EN ? 1 : 0);

    // Load that clears then sets the tap bit.
    cyc(1, MODE_LOAD, 0, 0, 8'h00);
    cyc(1, MODE_HOLD, 0, 0, 0);
    cyc(1, MODE_LOAD, 0, 0, 8'h40);
    cyc(1, MODE_HOLD, 0, 0, 0);
    #1 chk("tap_load", tap_rise, TAP_EN);
    cyc(1, MODE_HOLD, 0, 0, 0);
    #1 chk("tap_load_end", tap_rise, 0);

    cyc(1, MODE_HOLD, 0, 0, 0);
    #2;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
